dpll_trail_stack: RTL and testbench

Assignment trail for the DPLL engine. It is a LIFO of (variable, value, decision-flag) entries and tracks the current decision level. It supports single-cycle push/pop and a multi-cycle backtrack that unwinds to the most recent decision and returns that decision for the controller to flip. It sits between the DPLL control FSM and unit-propagation logic.

---
 rtl/dpll_defs.sv | 16 +
 rtl/trail_mem.sv | 21 ++
 rtl/dpll_trail_stack.sv | 127 ++++++++++++
 tb/tb_dpll_trail_stack.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dpll_defs.sv
// dpll_defs: packed trail-entry layout and trail FSM state encodings shared by the DPLL trail blocks.
package dpll_defs;
    // Entry layout, LSB first: value, decision flag, then the variable id.
    localparam int OFS_VAL = 0;
    localparam int OFS_DEC = 1;
    localparam int OFS_VAR = 2;

    function automatic int entry_w(input int var_w);
        return var_w + 2;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UNWIND = 1'b1
    } state_t;
endpackage

// File: rtl/trail_mem.sv
// trail_mem: DEPTH x W entry storage with one synchronous write port and an asynchronous read port.
module trail_mem #(
    parameter int W     = 10,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dpll_trail_stack.sv
// dpll_trail_stack: DPLL assignment trail (LIFO of var/value/decision) with decision-level
// tracking and a multi-cycle backtrack that unwinds to and returns the latest decision.
module dpll_trail_stack
    import dpll_defs::*;
#(
    parameter  int VAR_W = 8,
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [VAR_W-1:0] push_var,
    input  logic             push_val,
    input  logic             push_dec,
    input  logic             pop,
    input  logic             backtrack,
    output logic [VAR_W-1:0] top_var,
    output logic             top_val,
    output logic             top_dec,
    output logic             top_valid,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] level,
    output logic             empty,
    output logic             full,
    output logic             busy,
    output logic             bt_done,
    output logic [VAR_W-1:0] bt_var,
    output logic             bt_val,
    output logic             bt_fail,
    output logic             err_ovf,
    output logic             err_udf
);
    localparam int EW = entry_w(VAR_W);
    localparam int AW = $clog2(DEPTH);

    state_t           state, state_n;
    logic [CNT_W-1:0] count_n, level_n, top_idx;
    logic             done_n, fail_n, ovf_n, udf_n, we, replace;
    logic [EW-1:0]    wdata, rdata;

    assign empty     = count == '0;
    assign full      = count == CNT_W'(DEPTH);
    assign top_valid = !empty;
    assign busy      = state == ST_UNWIND;
    assign top_idx   = count - CNT_W'(1);
    assign top_var   = rdata[OFS_VAR +: VAR_W];
    assign top_val   = rdata[OFS_VAL];
    assign top_dec   = rdata[OFS_DEC];
    assign replace   = push && pop && !empty;
    assign we        = !busy && !backtrack && push && (replace || !full);

    always_comb begin
        wdata          = '0;
        wdata[OFS_VAL] = push_val;
        wdata[OFS_DEC] = push_dec;
        wdata[OFS_VAR +: VAR_W] = push_var;
    end

    trail_mem #(.W(EW), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (replace ? AW'(top_idx) : AW'(count)),
        .wdata (wdata),
        .raddr (AW'(top_idx)),
        .rdata (rdata)
    );

    always_comb begin
        state_n = state;
        count_n = count;
        level_n = level;
        done_n  = 1'b0;
        fail_n  = 1'b0;
        ovf_n   = 1'b0;
        udf_n   = 1'b0;
        if (state == ST_IDLE) begin
            if (backtrack) begin
                fail_n  = empty;
                state_n = empty ? ST_IDLE : ST_UNWIND;
            end else if (replace) begin
                level_n = level + CNT_W'(push_dec) - CNT_W'(top_dec);
            end else if (push) begin
                ovf_n   = full;
                count_n = full ? count : count + CNT_W'(1);
                level_n = full ? level : level + CNT_W'(push_dec);
            end else if (pop) begin
                udf_n   = empty;
                count_n = empty ? count : top_idx;
                level_n = empty ? level : level - CNT_W'(top_dec);
            end
        end else begin
            // One entry leaves per cycle; stop at the first decision or when the trail runs dry.
            count_n = top_idx;
            level_n = level - CNT_W'(top_dec);
            done_n  = top_dec;
            fail_n  = !top_dec && top_idx == '0;
            state_n = (done_n || fail_n) ? ST_IDLE : ST_UNWIND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            level   <= '0;
            bt_done <= 1'b0;
            bt_fail <= 1'b0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
            bt_var  <= '0;
            bt_val  <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            level   <= level_n;
            bt_done <= done_n;
            bt_fail <= fail_n;
            err_ovf <= ovf_n;
            err_udf <= udf_n;
            if (done_n) begin
                bt_var <= top_var;
                bt_val <= top_val;
            end
        end
    end
endmodule

// File: tb/tb_dpll_trail_stack.sv
// tb_dpll_trail_stack: directed self-checking bench for the DPLL assignment trail.
module tb_dpll_trail_stack;
    logic       clk, rst, push, push_val, push_dec, pop, backtrack;
    logic [7:0] push_var, top_var, bt_var;
    logic       top_val, top_dec, top_valid, empty, full, busy;
    logic       bt_done, bt_val, bt_fail, err_ovf, err_udf;
    logic [4:0] count, level;
    int checks = 0, failures = 0;

    dpll_trail_stack #(.VAR_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .push(push), .push_var(push_var), .push_val(push_val),
        .push_dec(push_dec), .pop(pop), .backtrack(backtrack), .top_var(top_var),
        .top_val(top_val), .top_dec(top_dec), .top_valid(top_valid), .count(count),
        .level(level), .empty(empty), .full(full), .busy(busy), .bt_done(bt_done),
        .bt_var(bt_var), .bt_val(bt_val), .bt_fail(bt_fail), .err_ovf(err_ovf),
        .err_udf(err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; backtrack = 1'b0;
        push_var = '0; push_val = 1'b0; push_dec = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic do_push(input logic [7:0] v, input logic val, input logic dec);
        push = 1'b1; push_var = v; push_val = val; push_dec = dec;
        step();
        push = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 5'd0 || level !== 5'd0) begin failures++; $display("FAIL reset_cnt count=%0d level=%0d exp=0/0", count, level); end
        checks++; if ({empty, full, busy, top_valid} !== 4'b1000) begin failures++; $display("FAIL reset_flags got=%b exp=1000", {empty, full, busy, top_valid}); end
        checks++; if ({bt_done, bt_fail, err_ovf, err_udf, bt_val} !== 5'b0 || bt_var !== 8'd0) begin failures++; $display("FAIL reset_pulses got=%b bt_var=%0d exp=0", {bt_done, bt_fail, err_ovf, err_udf, bt_val}, bt_var); end
    endtask

    task automatic test_push();
        do_reset();
        do_push(8'd5, 1'b1, 1'b1);
        do_push(8'd7, 1'b0, 1'b0);
        checks++; if (count !== 5'd2 || level !== 5'd1 || empty !== 1'b0) begin failures++; $display("FAIL push_cnt count=%0d level=%0d empty=%b exp=2/1/0", count, level, empty); end
        checks++; if ({top_var, top_val, top_dec} !== {8'd7, 1'b0, 1'b0}) begin failures++; $display("FAIL push_top got=(%0d,%b,%b) exp=(7,0,0)", top_var, top_val, top_dec); end
        pop = 1'b1; step(); pop = 1'b0;
        checks++; if (count !== 5'd1 || level !== 5'd1 || top_var !== 8'd5) begin failures++; $display("FAIL pop_imp count=%0d level=%0d top=%0d exp=1/1/5", count, level, top_var); end
        pop = 1'b1; step(); pop = 1'b0;
        checks++; if (count !== 5'd0 || level !== 5'd0 || top_valid !== 1'b0) begin failures++; $display("FAIL pop_dec count=%0d level=%0d tv=%b exp=0/0/0", count, level, top_valid); end
    endtask

    task automatic test_overflow();
        int ovf = 0;
        do_reset();
        for (int i = 0; i < 16; i++) do_push(8'(10 + i), i[0], (i % 4) == 0);
        checks++; if (full !== 1'b1 || count !== 5'd16 || level !== 5'd4) begin failures++; $display("FAIL fill full=%b count=%0d level=%0d exp=1/16/4", full, count, level); end
        do_push(8'd99, 1'b0, 1'b1);
        ovf += int'(err_ovf);
        checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", err_ovf); end
        step();
        ovf += int'(err_ovf);
        checks++; if (ovf != 1 || count !== 5'd16 || level !== 5'd4) begin failures++; $display("FAIL ovf_once pulses=%0d count=%0d level=%0d exp=1/16/4", ovf, count, level); end
        checks++; if ({top_var, top_val, top_dec} !== {8'd25, 1'b1, 1'b0}) begin failures++; $display("FAIL ovf_top got=(%0d,%b,%b) exp=(25,1,0)", top_var, top_val, top_dec); end
    endtask

    task automatic test_underflow();
        do_reset();
        pop = 1'b1; step(); pop = 1'b0;
        checks++; if (err_udf !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL udf got=%b count=%0d exp=1/0", err_udf, count); end
        step();
        checks++; if (err_udf !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", err_udf); end
        push = 1'b1; pop = 1'b1; push_var = 8'd11; push_val = 1'b1; push_dec = 1'b1;
        step(); push = 1'b0; pop = 1'b0;
        checks++; if (err_udf !== 1'b0 || count !== 5'd1 || level !== 5'd1 || top_var !== 8'd11) begin failures++; $display("FAIL pushpop_empty udf=%b count=%0d level=%0d top=%0d exp=0/1/1/11", err_udf, count, level, top_var); end
    endtask

    task automatic test_backtrack_done();
        int n = 0, dones = 0;
        do_reset();
        do_push(8'd3, 1'b1, 1'b1);
        do_push(8'd4, 1'b0, 1'b0);
        do_push(8'd6, 1'b1, 1'b1);
        do_push(8'd8, 1'b1, 1'b0);
        do_push(8'd9, 1'b0, 1'b0);
        backtrack = 1'b1; step(); backtrack = 1'b0;
        while (busy === 1'b1 && n < 20) begin n++; dones += int'(bt_done); step(); end
        checks++; if (n != 3 || dones != 0) begin failures++; $display("FAIL bt_busy cycles=%0d early_done=%0d exp=3/0", n, dones); end
        checks++; if (bt_done !== 1'b1 || bt_fail !== 1'b0 || bt_var !== 8'd6 || bt_val !== 1'b1) begin failures++; $display("FAIL bt_done done=%b fail=%b var=%0d val=%b exp=1/0/6/1", bt_done, bt_fail, bt_var, bt_val); end
        checks++; if (count !== 5'd2 || level !== 5'd1 || {top_var, top_val, top_dec} !== {8'd4, 1'b0, 1'b0}) begin failures++; $display("FAIL bt_state count=%0d level=%0d top=(%0d,%b,%b) exp=2/1/(4,0,0)", count, level, top_var, top_val, top_dec); end
        step();
        checks++; if (bt_done !== 1'b0 || bt_var !== 8'd6 || bt_val !== 1'b1) begin failures++; $display("FAIL bt_hold done=%b var=%0d val=%b exp=0/6/1", bt_done, bt_var, bt_val); end
    endtask

    task automatic test_backtrack_fail();
        int n = 0, dones = 0;
        do_reset();
        do_push(8'd2, 1'b1, 1'b0);
        do_push(8'd4, 1'b0, 1'b0);
        backtrack = 1'b1; step(); backtrack = 1'b0;
        while (busy === 1'b1 && n < 20) begin n++; dones += int'(bt_done); step(); end
        dones += int'(bt_done);
        checks++; if (n != 2 || bt_fail !== 1'b1 || dones != 0) begin failures++; $display("FAIL bt_fail cycles=%0d fail=%b dones=%0d exp=2/1/0", n, bt_fail, dones); end
        checks++; if (count !== 5'd0 || level !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL bt_fail_state count=%0d level=%0d empty=%b exp=0/0/1", count, level, empty); end
        backtrack = 1'b1; step(); backtrack = 1'b0;
        checks++; if (bt_fail !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bt_empty fail=%b busy=%b exp=1/0", bt_fail, busy); end
        step();
        checks++; if (bt_fail !== 1'b0) begin failures++; $display("FAIL bt_empty_clear got=%b exp=0", bt_fail); end
    endtask

    task automatic test_replace_and_busy();
        int n = 0, errs = 0;
        do_reset();
        do_push(8'd4, 1'b0, 1'b1);
        push = 1'b1; pop = 1'b1; push_var = 8'd5; push_val = 1'b1; push_dec = 1'b0;
        step(); push = 1'b0; pop = 1'b0;
        checks++; if (count !== 5'd1 || level !== 5'd0 || {top_var, top_val, top_dec} !== {8'd5, 1'b1, 1'b0}) begin failures++; $display("FAIL replace count=%0d level=%0d top=(%0d,%b,%b) exp=1/0/(5,1,0)", count, level, top_var, top_val, top_dec); end
        do_reset();
        do_push(8'd1, 1'b1, 1'b1);
        do_push(8'd2, 1'b0, 1'b0);
        do_push(8'd3, 1'b0, 1'b0);
        backtrack = 1'b1; step(); backtrack = 1'b0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            push = 1'b1; pop = n[0]; backtrack = 1'b1; push_var = 8'd77; push_dec = 1'b1;
            step();
            errs += int'(err_ovf) + int'(err_udf);
        end
        push = 1'b0; pop = 1'b0; backtrack = 1'b0;
        checks++; if (n != 3 || bt_done !== 1'b1 || bt_var !== 8'd1 || errs != 0) begin failures++; $display("FAIL busy_ignore cycles=%0d done=%b var=%0d errs=%0d exp=3/1/1/0", n, bt_done, bt_var, errs); end
        checks++; if (count !== 5'd0 || level !== 5'd0) begin failures++; $display("FAIL busy_state count=%0d level=%0d exp=0/0", count, level); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int i = 0; i < 4; i++) do_push(8'(20 + i), 1'b0, 1'b0);
        backtrack = 1'b1; step(); backtrack = 1'b0;
        step();
        checks++; if (busy !== 1'b1 || count !== 5'd3) begin failures++; $display("FAIL mid_busy busy=%b count=%0d exp=1/3", busy, count); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (count !== 5'd0 || level !== 5'd0 || busy !== 1'b0 || bt_done !== 1'b0 || bt_fail !== 1'b0) begin failures++; $display("FAIL mid_rst count=%0d level=%0d busy=%b done=%b fail=%b exp=0/0/0/0/0", count, level, busy, bt_done, bt_fail); end
        step();
        checks++; if (bt_done !== 1'b0 || bt_fail !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_after done=%b fail=%b busy=%b exp=0/0/0", bt_done, bt_fail, busy); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_overflow();
        test_underflow();
        test_backtrack_done();
        test_backtrack_fail();
        test_replace_and_busy();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
